pdp_pool1d_lanes: RTL

- Parametrised multi-lane 1D (width-direction) pooling engine for the PDP datapath.
- Sits between the SDP-to-PDP stream and the PDP write path.
- Reduces each non-overlapping kernel window along a line to one output per lane, using max, min or average.
- Generalises the fixed 8x16-bit PDP input stream to configurable lane count, data width, kernel size and line geometry, and supports partial windows at the end of a line.

---
 rtl/pdp_pool1d_lanes_if.sv | 28 ++
 rtl/pdp_pool1d_lanes.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/pdp_pool1d_lanes_if.sv
// Stream bundle for the 1D pooling engine.
// Input stream : in_pvld/in_prdy/in_pd
// Output stream: out_pvld/out_prdy/out_pd/out_eol
// Lane i of a beat is in_pd[i] (== flat bits [i*DW +: DW]).
// slave  : view from the pooling engine
// master : view from the producer/consumer around it
interface pdp_pool1d_lanes_if #(
  parameter int LANES = 8,
  parameter int DW    = 16
);
  logic                       in_pvld;
  logic                       in_prdy;
  logic [LANES-1:0][DW-1:0]   in_pd;
  logic                       out_pvld;
  logic                       out_prdy;
  logic [LANES-1:0][DW-1:0]   out_pd;
  logic                       out_eol;

  modport slave (
    input  in_pvld, in_pd, out_prdy,
    output in_prdy, out_pvld, out_pd, out_eol
  );

  modport master (
    output in_pvld, in_pd, out_prdy,
    input  in_prdy, out_pvld, out_pd, out_eol
  );
endinterface

// File: rtl/pdp_pool1d_lanes.sv
// Multi-lane 1D (width-direction) pooling engine.
// Reduces each non-overlapping window of cfg_kernel_w+1 pixels along a line
// to one value per lane (max, min or rounded/saturated average). A window
// that is cut short by the end of a line is emitted as-is.
// Ports:
//   nvdla_core_clk / nvdla_core_rst : clock, async active-high reset
//   op_en                           : start pulse (IDLE only)
//   cfg_*                           : operation config, latched on op_en
//   op_done                         : one-cycle pulse after the final output
//   io (slave)                      : input / output streams

// Per-lane accumulator and result formatter.
//   i_ld    : input handshake, update the accumulator
//   i_first : first pixel of a window, accumulator restarts from the input
//   o_res   : result including the current pixel (valid when i_ld closes)
module pdp_pool1d_lane #(
  parameter int DW = 16,
  parameter int KW = 3
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_ld,
  input  logic          i_first,
  input  logic [1:0]    i_mode,
  input  logic [16:0]   i_recip,
  input  logic [DW-1:0] i_in,
  output logic [DW-1:0] o_res
);
  localparam int AW = DW + KW;
  localparam int PW = AW + 18;
  localparam logic signed [PW-1:0] SMAX = {{(PW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [PW-1:0] SMIN = {{(PW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  logic signed [AW-1:0] r_acc;
  logic signed [AW-1:0] w_in;
  logic signed [AW-1:0] w_nxt;
  logic signed [PW-1:0] w_prod;
  logic signed [PW-1:0] w_rnd;
  logic signed [PW-1:0] w_sh;
  logic        [DW-1:0] w_avg;

  assign w_in = {{KW{i_in[DW-1]}}, i_in};

  always_comb begin
    w_nxt = w_in;
    if (!i_first) begin
      case (i_mode)
        2'd1:    w_nxt = (w_in < r_acc) ? w_in : r_acc;
        2'd2:    w_nxt = r_acc + w_in;
        default: w_nxt = (w_in > r_acc) ? w_in : r_acc;
      endcase
    end
  end

  // Low PW bits of the product are identical for signed/unsigned operands,
  // so the zero-extended reciprocal acts as the positive Q1.16 factor.
  assign w_prod = {{(PW-AW){w_nxt[AW-1]}}, w_nxt} * {{(PW-17){1'b0}}, i_recip};
  assign w_rnd  = w_prod + {{(PW-16){1'b0}}, 16'h8000};
  assign w_sh   = w_rnd >>> 16;

  always_comb begin
    w_avg = w_sh[DW-1:0];
    if (w_sh > SMAX)      w_avg = SMAX[DW-1:0];
    else if (w_sh < SMIN) w_avg = SMIN[DW-1:0];
  end

  assign o_res = (i_mode == 2'd2) ? w_avg : w_nxt[DW-1:0];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)     r_acc <= '0;
    else if (i_ld) r_acc <= w_nxt;
  end
endmodule

module pdp_pool1d_lanes #(
  parameter int LANES = 8,
  parameter int DW    = 16,
  parameter int KW    = 3,
  parameter int LW    = 13
) (
  input  logic                nvdla_core_clk,
  input  logic                nvdla_core_rst,
  input  logic                op_en,
  input  logic [1:0]          cfg_mode,
  input  logic [KW-1:0]       cfg_kernel_w,
  input  logic [LW-1:0]       cfg_line_w,
  input  logic [LW-1:0]       cfg_line_num,
  input  logic [16:0]         cfg_recip,
  output logic                op_done,
  pdp_pool1d_lanes_if.slave   io
);
  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t                   r_state;
  logic [1:0]               r_mode;
  logic [KW-1:0]            r_kernel_w;
  logic [LW-1:0]            r_line_w;
  logic [LW-1:0]            r_line_num;
  logic [16:0]              r_recip;
  logic [KW-1:0]            r_kcnt;
  logic [LW-1:0]            r_pcnt;
  logic [LW-1:0]            r_lcnt;
  logic                     r_out_vld;
  logic [LANES-1:0][DW-1:0] r_out_pd;
  logic                     r_out_eol;
  logic                     r_op_done;

  logic                     w_in_rdy;
  logic                     w_hs;
  logic                     w_eol_px;
  logic                     w_win_end;
  logic                     w_last_px;
  logic                     w_kfirst;
  logic [LANES-1:0][DW-1:0] w_in;
  logic [LANES-1:0][DW-1:0] w_res;

  // Single output entry: accept input only if the entry is free or draining.
  assign w_in_rdy  = (r_state == RUN) && (!r_out_vld || io.out_prdy);
  assign w_hs      = io.in_pvld && w_in_rdy;
  assign w_eol_px  = (r_pcnt == r_line_w);
  assign w_win_end = (r_kcnt == r_kernel_w) || w_eol_px;
  assign w_last_px = w_eol_px && (r_lcnt == r_line_num);
  assign w_kfirst  = (r_kcnt == '0);
  assign w_in      = io.in_pd;

  pdp_pool1d_lane #(.DW(DW), .KW(KW)) u_lane [LANES-1:0] (
    .i_clk   (nvdla_core_clk),
    .i_rst   (nvdla_core_rst),
    .i_ld    (w_hs),
    .i_first (w_kfirst),
    .i_mode  (r_mode),
    .i_recip (r_recip),
    .i_in    (w_in),
    .o_res   (w_res)
  );

  // Output entry: loads on window close, which can coincide with the
  // previous beat draining (no bubble).
  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      r_out_vld <= 1'b0;
      r_out_pd  <= '0;
      r_out_eol <= 1'b0;
    end else if (w_hs && w_win_end) begin
      r_out_vld <= 1'b1;
      r_out_pd  <= w_res;
      r_out_eol <= w_eol_px;
    end else if (io.out_prdy) begin
      r_out_vld <= 1'b0;
    end
  end

  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      r_state    <= IDLE;
      r_mode     <= '0;
      r_kernel_w <= '0;
      r_line_w   <= '0;
      r_line_num <= '0;
      r_recip    <= '0;
      r_kcnt     <= '0;
      r_pcnt     <= '0;
      r_lcnt     <= '0;
      r_op_done  <= 1'b0;
    end else begin
      r_op_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (op_en) begin
            r_mode     <= cfg_mode;
            r_kernel_w <= cfg_kernel_w;
            r_line_w   <= cfg_line_w;
            r_line_num <= cfg_line_num;
            r_recip    <= cfg_recip;
            r_kcnt     <= '0;
            r_pcnt     <= '0;
            r_lcnt     <= '0;
            r_state    <= RUN;
          end
        end
        RUN: begin
          if (w_hs) begin
            r_kcnt <= w_win_end ? '0 : r_kcnt + 1'b1;
            r_pcnt <= w_eol_px  ? '0 : r_pcnt + 1'b1;
            if (w_eol_px) r_lcnt <= r_lcnt + 1'b1;
            if (w_last_px) begin
              r_lcnt  <= '0;
              r_state <= FLUSH;
            end
          end
        end
        FLUSH: begin
          // The last window's result is the only entry left to drain.
          if (r_out_vld && io.out_prdy) begin
            r_op_done <= 1'b1;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign io.in_prdy  = w_in_rdy;
  assign io.out_pvld = r_out_vld;
  assign io.out_pd   = r_out_pd;
  assign io.out_eol  = r_out_eol;
  assign op_done     = r_op_done;
endmodule
